// File: rtl/dual_port_blockram_arbiter_pkg.sv
// Shared types for the block-RAM arbiter: sequencer states and the
// lane slice-offset helper used for the flattened request/response buses.
package dual_port_blockram_arbiter_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/dual_port_blockram_arbiter_if.sv
// Requester-side bus: per-lane valid/ready request and fixed-latency response.
interface dual_port_blockram_arbiter_if #(
  parameter int NUM_REQUESTER               = 4,
  parameter int SET_PTR_WIDTH_IN_BITS       = 6,
  parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 64
);
  localparam int N = NUM_REQUESTER;
  localparam int A = SET_PTR_WIDTH_IN_BITS;
  localparam int W = SINGLE_ELEMENT_SIZE_IN_BITS;

  logic [N-1:0]   request_valid_in;
  logic [N-1:0]   request_is_write_in;
  logic [N*A-1:0] request_set_addr_in;
  logic [N*W-1:0] request_element_in;
  logic [N-1:0]   request_ready_out;
  logic [N-1:0]   response_valid_out;
  logic [N*W-1:0] response_element_out;

  modport master (
    output request_valid_in, request_is_write_in, request_set_addr_in, request_element_in,
    input  request_ready_out, response_valid_out, response_element_out
  );

  modport slave (
    input  request_valid_in, request_is_write_in, request_set_addr_in, request_element_in,
    output request_ready_out, response_valid_out, response_element_out
  );
endinterface

// File: rtl/dual_port_blockram_arbiter_round_robin_arbiter.sv
// Round-robin arbiter: scans from the pointer upward modulo N, pointer
// moves to winner+1 on a grant and holds otherwise.
module round_robin_arbiter #(
  parameter int NUM_REQUESTER               = 4,
  parameter int REQUESTER_PTR_WIDTH_IN_BITS = 2
) (
  input  logic                                   clk_in,
  input  logic                                   reset_n_in,
  input  logic [NUM_REQUESTER-1:0]               request_in,
  output logic [NUM_REQUESTER-1:0]               grant_out,
  output logic [REQUESTER_PTR_WIDTH_IN_BITS-1:0] grant_idx_out,
  output logic                                   grant_valid_out
);
  localparam int N = NUM_REQUESTER;
  localparam int P = REQUESTER_PTR_WIDTH_IN_BITS;

  logic [P-1:0] ptr_q;
  logic [P:0]   sum;
  logic [P-1:0] idx;

  always_comb begin
    grant_out       = '0;
    grant_idx_out   = '0;
    grant_valid_out = 1'b0;
    sum             = '0;
    idx             = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_q} + (P+1)'(k);
      if (sum >= (P+1)'(N)) sum = sum - (P+1)'(N);
      idx = sum[P-1:0];
      if (!grant_valid_out && request_in[idx]) begin
        grant_valid_out = 1'b1;
        grant_out[idx]  = 1'b1;
        grant_idx_out   = idx;
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in)
      ptr_q <= '0;
    else if (grant_valid_out)
      ptr_q <= (grant_idx_out == P'(N-1)) ? '0 : grant_idx_out + P'(1);
  end
endmodule

// File: rtl/dual_port_blockram_arbiter.sv
// Shares one dual-port block RAM among N requesters: zero-fills the RAM after
// reset, then issues up to one read and one write per cycle with 1-cycle responses.
module dual_port_blockram_arbiter
  import dual_port_blockram_arbiter_pkg::*;
#(
  parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 64,
  parameter int NUMBER_SET                  = 64,
  parameter int SET_PTR_WIDTH_IN_BITS       = 6,
  parameter int NUM_REQUESTER               = 4,
  parameter int REQUESTER_PTR_WIDTH_IN_BITS = 2
) (
  input  logic                                   clk_in,
  input  logic                                   reset_n_in,
  dual_port_blockram_arbiter_if.slave            req_if,
  output logic                                   init_done_out,
  output logic                                   ram_read_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]       ram_read_set_addr_out,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] ram_read_element_in,
  output logic                                   ram_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]       ram_write_set_addr_out,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] ram_write_element_out,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] ram_evict_element_in
);
  localparam int N = NUM_REQUESTER;
  localparam int A = SET_PTR_WIDTH_IN_BITS;
  localparam int W = SINGLE_ELEMENT_SIZE_IN_BITS;
  localparam int P = REQUESTER_PTR_WIDTH_IN_BITS;

  typedef struct packed {
    logic         rd_vld;
    logic         wr_vld;
    logic [P-1:0] rd_id;
    logic [P-1:0] wr_id;
    logic         fwd;
    logic [W-1:0] fwd_data;
  } issue_t;

  state_t                 state_q;
  logic   [A-1:0]         init_cnt_q;
  issue_t                 iss_q;
  logic                   run;
  logic   [N-1:0][A-1:0]  addr_v;
  logic   [N-1:0][W-1:0]  data_v;
  logic   [N-1:0]         rd_req, wr_req, rd_gnt, wr_gnt, rsp_vld;
  logic   [N-1:0][W-1:0]  rsp_elem;
  logic   [P-1:0]         rd_idx, wr_idx;
  logic                   rd_any, wr_any, collide;

  assign run    = (state_q == ST_RUN);
  assign rd_req = req_if.request_valid_in & ~req_if.request_is_write_in & {N{run}};
  assign wr_req = req_if.request_valid_in &  req_if.request_is_write_in & {N{run}};

  round_robin_arbiter #(.NUM_REQUESTER(N), .REQUESTER_PTR_WIDTH_IN_BITS(P)) u_rd_arb (
    .clk_in, .reset_n_in, .request_in(rd_req),
    .grant_out(rd_gnt), .grant_idx_out(rd_idx), .grant_valid_out(rd_any)
  );

  round_robin_arbiter #(.NUM_REQUESTER(N), .REQUESTER_PTR_WIDTH_IN_BITS(P)) u_wr_arb (
    .clk_in, .reset_n_in, .request_in(wr_req),
    .grant_out(wr_gnt), .grant_idx_out(wr_idx), .grant_valid_out(wr_any)
  );

  assign req_if.request_ready_out = rd_gnt | wr_gnt;
  // RAM returns old data on a same-set collision, so the read lane takes the write data.
  assign collide = rd_any & wr_any & (addr_v[rd_idx] == addr_v[wr_idx]);

  always_comb begin
    ram_read_en_out        = 1'b1;
    ram_write_en_out       = 1'b1;
    ram_read_set_addr_out  = init_cnt_q;
    ram_write_set_addr_out = init_cnt_q;
    ram_write_element_out  = '0;
    if (run) begin
      ram_read_en_out        = rd_any | wr_any;
      ram_write_en_out       = wr_any;
      ram_read_set_addr_out  = rd_any ? addr_v[rd_idx] : addr_v[wr_idx];
      ram_write_set_addr_out = addr_v[wr_idx];
      ram_write_element_out  = data_v[wr_idx];
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q       <= ST_INIT;
      init_cnt_q    <= '0;
      init_done_out <= 1'b0;
      iss_q         <= '0;
    end else begin
      iss_q <= '{rd_vld: rd_any, wr_vld: wr_any, rd_id: rd_idx, wr_id: wr_idx,
                 fwd: collide, fwd_data: data_v[wr_idx]};
      case (state_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + A'(1);
          if (init_cnt_q == A'(NUMBER_SET-1)) begin
            state_q       <= ST_RUN;
            init_done_out <= 1'b1;
          end
        end
        default: init_done_out <= 1'b1;
      endcase
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic         rd_hit, wr_hit;
    logic [W-1:0] hold_q;

    assign addr_v[i] = req_if.request_set_addr_in[slice_lo(i, A) +: A];
    assign data_v[i] = req_if.request_element_in[slice_lo(i, W) +: W];
    assign rd_hit    = iss_q.rd_vld && (iss_q.rd_id == P'(i));
    assign wr_hit    = iss_q.wr_vld && (iss_q.wr_id == P'(i));
    assign rsp_vld[i] = rd_hit | wr_hit;
    // Non-responding lanes present the last value they returned.
    assign rsp_elem[i] = rd_hit ? (iss_q.fwd ? iss_q.fwd_data : ram_read_element_in)
                       : wr_hit ? ram_evict_element_in : hold_q;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in)     hold_q <= '0;
      else if (rsp_vld[i]) hold_q <= rsp_elem[i];
    end
  end

  assign req_if.response_valid_out   = rsp_vld;
  assign req_if.response_element_out = rsp_elem;
endmodule

// File: tb/tb_dual_port_blockram_arbiter.sv
// Directed bench for dual_port_blockram_arbiter with a behavioural dual-port RAM.
module tb_dual_port_blockram_arbiter;
  localparam int N = 4, A = 6, W = 64, S = 64;

  logic clk = 1'b0, rst_n = 1'b0;
  logic init_done, ram_re, ram_we;
  logic [A-1:0] ram_raddr, ram_waddr;
  logic [W-1:0] ram_wdata, ram_rd_q, ram_ev_q;
  logic [W-1:0] mem [S];
  int checks = 0, passed = 0;

  always #5 clk = ~clk;

  dual_port_blockram_arbiter_if #(.NUM_REQUESTER(N), .SET_PTR_WIDTH_IN_BITS(A),
                                  .SINGLE_ELEMENT_SIZE_IN_BITS(W)) bus ();

  dual_port_blockram_arbiter #(
    .SINGLE_ELEMENT_SIZE_IN_BITS(W), .NUMBER_SET(S), .SET_PTR_WIDTH_IN_BITS(A),
    .NUM_REQUESTER(N), .REQUESTER_PTR_WIDTH_IN_BITS(2)
  ) dut (
    .clk_in(clk), .reset_n_in(rst_n), .req_if(bus), .init_done_out(init_done),
    .ram_read_en_out(ram_re), .ram_read_set_addr_out(ram_raddr), .ram_read_element_in(ram_rd_q),
    .ram_write_en_out(ram_we), .ram_write_set_addr_out(ram_waddr),
    .ram_write_element_out(ram_wdata), .ram_evict_element_in(ram_ev_q)
  );

  // RAM: registered read (old data on collision), eviction of prior contents, write only with read enable.
  always @(posedge clk) begin
    if (ram_re) begin
      ram_rd_q <= mem[ram_raddr];
      if (ram_we) begin
        ram_ev_q <= mem[ram_waddr];
        mem[ram_waddr] <= ram_wdata;
      end
    end
  end

  function automatic logic [W-1:0] rsp(input int i);
    return bus.response_element_out[i*W +: W];
  endfunction

  task automatic drive(input int i, input logic v, input logic w, input logic [A-1:0] a, input logic [W-1:0] d);
    bus.request_valid_in[i]            = v;
    bus.request_is_write_in[i]         = w;
    bus.request_set_addr_in[i*A +: A]  = a;
    bus.request_element_in[i*W +: W]   = d;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.request_ready_out !== 4'b0) $display("FAIL reset_ready got %b want 0000", bus.request_ready_out); else passed++;
    checks++; if (init_done !== 1'b0) $display("FAIL reset_init_done got %b want 0", init_done); else passed++;
    checks++; if (bus.response_valid_out !== 4'b0) $display("FAIL reset_rsp_valid got %b want 0000", bus.response_valid_out); else passed++;
    checks++; if (bus.response_element_out !== '0) $display("FAIL reset_rsp_elem got %h want 0", bus.response_element_out); else passed++;
  endtask

  task automatic test_init_sequence;
    logic [A-1:0] k6;
    for (int i = 0; i < N; i++) drive(i, 1'b1, 1'b0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < S; k++) begin
      k6 = A'(k);
      checks++;
      if ({bus.request_ready_out, ram_we, ram_re, ram_waddr, ram_raddr, ram_wdata, init_done}
          !== {4'b0, 1'b1, 1'b1, k6, k6, 64'h0, 1'b0})
        $display("FAIL init_cycle_%0d got rdy=%b we=%b re=%b wa=%0d ra=%0d wd=%h done=%b want rdy=0000 we=1 re=1 wa=ra=%0d wd=0 done=0",
                 k, bus.request_ready_out, ram_we, ram_re, ram_waddr, ram_raddr, ram_wdata, init_done, k);
      else passed++;
      @(posedge clk); #1;
    end
    bus.request_valid_in = '0;
    #1;
    checks++; if (init_done !== 1'b1) $display("FAIL init_done got %b want 1", init_done); else passed++;
  endtask

  task automatic test_init_read(input int id, input logic [A-1:0] set);
    drive(id, 1'b1, 1'b0, set, '0);
    #1;
    checks++; if (bus.request_ready_out !== 4'(1 << id)) $display("FAIL init_read_ready got %b want %b", bus.request_ready_out, 4'(1 << id)); else passed++;
    @(posedge clk); #1;
    bus.request_valid_in = '0;
    checks++; if (bus.response_valid_out !== 4'(1 << id)) $display("FAIL init_read_rsp_valid got %b want %b", bus.response_valid_out, 4'(1 << id)); else passed++;
    checks++; if (rsp(id) !== 64'h0) $display("FAIL init_read_data got %h want 0", rsp(id)); else passed++;
    @(posedge clk); #1;
    checks++; if (bus.response_valid_out !== 4'b0) $display("FAIL init_read_pulse got %b want 0000", bus.response_valid_out); else passed++;
  endtask

  task automatic test_back_to_back;
    drive(1, 1'b1, 1'b1, 6'd3, 64'hAAAA);
    #1;
    checks++; if (bus.request_ready_out !== 4'b0010) $display("FAIL b2b_wr_ready got %b want 0010", bus.request_ready_out); else passed++;
    @(posedge clk); #1;
    bus.request_valid_in = '0;
    drive(2, 1'b1, 1'b0, 6'd3, '0);
    #1;
    checks++; if (bus.response_valid_out !== 4'b0010) $display("FAIL b2b_wr_rsp_valid got %b want 0010", bus.response_valid_out); else passed++;
    checks++; if (rsp(1) !== 64'h0) $display("FAIL b2b_evict got %h want 0", rsp(1)); else passed++;
    checks++; if (bus.request_ready_out !== 4'b0100) $display("FAIL b2b_rd_ready got %b want 0100", bus.request_ready_out); else passed++;
    @(posedge clk); #1;
    bus.request_valid_in = '0;
    checks++; if (bus.response_valid_out !== 4'b0100) $display("FAIL b2b_rd_rsp_valid got %b want 0100", bus.response_valid_out); else passed++;
    checks++; if (rsp(2) !== 64'hAAAA) $display("FAIL b2b_rd_data got %h want aaaa", rsp(2)); else passed++;
  endtask

  task automatic test_collision;
    drive(0, 1'b1, 1'b1, 6'd7, 64'h1234);
    drive(3, 1'b1, 1'b0, 6'd7, '0);
    #1;
    checks++; if (bus.request_ready_out !== 4'b1001) $display("FAIL coll_ready got %b want 1001", bus.request_ready_out); else passed++;
    checks++; if ({ram_re, ram_we, ram_waddr} !== {1'b1, 1'b1, 6'd7}) $display("FAIL coll_ram got re=%b we=%b wa=%0d want re=1 we=1 wa=7", ram_re, ram_we, ram_waddr); else passed++;
    @(posedge clk); #1;
    bus.request_valid_in = '0;
    checks++; if (bus.response_valid_out !== 4'b1001) $display("FAIL coll_rsp_valid got %b want 1001", bus.response_valid_out); else passed++;
    checks++; if (rsp(3) !== 64'h1234) $display("FAIL coll_fwd_data got %h want 1234", rsp(3)); else passed++;
    checks++; if (rsp(0) !== 64'h0) $display("FAIL coll_evict got %h want 0", rsp(0)); else passed++;
  endtask

  task automatic test_round_robin;
    int           exp_gnt [5] = '{0, 1, 2, 3, 0};
    logic [W-1:0] exp_dat [5] = '{64'hAAAA, 64'h1234, 64'h0, 64'hAAAA, 64'hAAAA};
    logic [A-1:0] sets    [4] = '{6'd3, 6'd7, 6'd5, 6'd3};
    for (int i = 0; i < N; i++) drive(i, 1'b1, 1'b0, sets[i], '0);
    #1;
    for (int c = 0; c <= 5; c++) begin
      if (c == 5) begin
        bus.request_valid_in = '0;
        #1;
      end else begin
        checks++; if (bus.request_ready_out !== 4'(1 << exp_gnt[c])) $display("FAIL rr_grant_%0d got %b want %b", c, bus.request_ready_out, 4'(1 << exp_gnt[c])); else passed++;
      end
      if (c > 0) begin
        checks++; if (bus.response_valid_out !== 4'(1 << exp_gnt[c-1])) $display("FAIL rr_rsp_valid_%0d got %b want %b", c, bus.response_valid_out, 4'(1 << exp_gnt[c-1])); else passed++;
        checks++; if (rsp(exp_gnt[c-1]) !== exp_dat[c-1]) $display("FAIL rr_rsp_data_%0d got %h want %h", c, rsp(exp_gnt[c-1]), exp_dat[c-1]); else passed++;
      end
      if (c < 5) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_rd_wr_concurrent;
    drive(0, 1'b1, 1'b0, 6'd9,  '0);
    drive(1, 1'b1, 1'b1, 6'd10, 64'h1010);
    drive(2, 1'b1, 1'b1, 6'd11, 64'h2020);
    #1;
    checks++; if (bus.request_ready_out !== 4'b0011) $display("FAIL conc_ready_a got %b want 0011", bus.request_ready_out); else passed++;
    checks++; if ({ram_re, ram_we, ram_raddr, ram_waddr, ram_wdata} !== {1'b1, 1'b1, 6'd9, 6'd10, 64'h1010})
      $display("FAIL conc_ram_a got re=%b we=%b ra=%0d wa=%0d wd=%h want re=1 we=1 ra=9 wa=10 wd=1010", ram_re, ram_we, ram_raddr, ram_waddr, ram_wdata); else passed++;
    @(posedge clk); #1;
    bus.request_valid_in[1:0] = 2'b00;
    #1;
    checks++; if (bus.request_ready_out !== 4'b0100) $display("FAIL conc_ready_b got %b want 0100", bus.request_ready_out); else passed++;
    checks++; if ({ram_re, ram_we, ram_waddr, ram_wdata} !== {1'b1, 1'b1, 6'd11, 64'h2020})
      $display("FAIL conc_ram_b got re=%b we=%b wa=%0d wd=%h want re=1 we=1 wa=11 wd=2020", ram_re, ram_we, ram_waddr, ram_wdata); else passed++;
    checks++; if (bus.response_valid_out !== 4'b0011) $display("FAIL conc_rsp_valid_a got %b want 0011", bus.response_valid_out); else passed++;
    checks++; if ({rsp(0), rsp(1)} !== {64'h0, 64'h0}) $display("FAIL conc_rsp_data_a got %h %h want 0 0", rsp(0), rsp(1)); else passed++;
    checks++; if (rsp(3) !== 64'hAAAA) $display("FAIL conc_hold got %h want aaaa", rsp(3)); else passed++;
    @(posedge clk); #1;
    bus.request_valid_in = '0;
    #1;
    checks++; if (bus.response_valid_out !== 4'b0100) $display("FAIL conc_rsp_valid_b got %b want 0100", bus.response_valid_out); else passed++;
    checks++; if (rsp(2) !== 64'h0) $display("FAIL conc_rsp_data_b got %h want 0", rsp(2)); else passed++;
    checks++; if ({ram_re, ram_we} !== 2'b00) $display("FAIL conc_idle got re=%b we=%b want 0 0", ram_re, ram_we); else passed++;
  endtask

  task automatic test_reset_mid;
    drive(0, 1'b1, 1'b0, 6'd3, '0);
    #1;
    checks++; if (bus.request_ready_out !== 4'b0001) $display("FAIL mid_ready got %b want 0001", bus.request_ready_out); else passed++;
    @(posedge clk); #1;
    bus.request_valid_in = '0;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.response_valid_out !== 4'b0) $display("FAIL mid_rsp_dropped got %b want 0000", bus.response_valid_out); else passed++;
    checks++; if (init_done !== 1'b0) $display("FAIL mid_init_done got %b want 0", init_done); else passed++;
    @(posedge clk); #1;
    test_init_sequence();
    test_init_read(0, 6'd3);
  endtask

  initial begin
    for (int i = 0; i < S; i++) mem[i] = 64'hDEAD_0000 + 64'(i);
    bus.request_valid_in    = '0;
    bus.request_is_write_in = '0;
    bus.request_set_addr_in = '0;
    bus.request_element_in  = '0;
    test_reset();
    test_init_sequence();
    test_init_read(0, 6'd5);
    test_back_to_back();
    test_collision();
    test_round_robin();
    test_rd_wr_concurrent();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
